// File: rtl/decode_execute_pipe_pkg.sv
// ============================================================================
// Module : decode_execute_pipe_pkg
// Brief  : Opcode encoding and shared constants for the decode/execute pipe.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package decode_execute_pipe_pkg;

  localparam int c_op_w = 3;

  typedef enum logic [c_op_w-1:0] {
    OP_SUB = 3'b000,
    OP_ADD = 3'b001,
    OP_OR  = 3'b010,
    OP_AND = 3'b011,
    OP_SRA = 3'b100,
    OP_ROL = 3'b101,
    OP_SLT = 3'b110,
    OP_SEQ = 3'b111
  } op_e;

  // Only the arithmetic ops produce a meaningful carry/borrow.
  function automatic logic op_has_carry(input op_e op);
    return (op == OP_SUB) || (op == OP_ADD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/de_result_fifo.sv
// ============================================================================
// Module : de_result_fifo
// Brief  : Synchronous in-order FIFO with occupancy count; storage is cleared
//          by reset so the head never reads X.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module de_result_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int c_aw = $clog2(DEPTH);
  localparam logic [c_aw:0] c_depth = (c_aw + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign w_full    = (r_count == c_depth);
  assign w_do_pop  = pop & ~empty;
  // At full a simultaneous pop frees the slot the push lands in.
  assign w_do_push = push & (~w_full | w_do_pop);
  assign dout      = r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/decode_execute_pipe.sv
// ============================================================================
// Module : decode_execute_pipe
// Brief  : Two-stage decode/execute ALU with carry/zero flags, credit-based
//          input flow control and an in-order result FIFO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module decode_execute_pipe
  import decode_execute_pipe_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [c_op_w-1:0]  in_op,
  input  logic [WIDTH-1:0]   in_rs,
  input  logic [WIDTH-1:0]   in_rt,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_rd,
  output logic               out_carry,
  output logic               out_zero,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int c_fw = WIDTH + 2 + TAG_W;
  localparam int c_cw = $clog2(DEPTH) + 1;
  localparam logic [c_cw:0] c_depth = (c_cw + 1)'(DEPTH);

  logic               w_accept;
  logic               r_s1_valid;
  op_e                r_s1_op;
  logic [WIDTH-1:0]   r_s1_rs;
  logic [WIDTH-1:0]   r_s1_rt;
  logic [TAG_W-1:0]   r_s1_tag;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_rd;
  logic               w_carry;
  logic               w_zero;

  logic               r_s2_valid;
  logic [c_fw-1:0]    r_s2_data;

  logic [c_fw-1:0]    w_fifo_dout;
  logic [c_cw-1:0]    w_fifo_count;
  logic               w_fifo_empty;
  logic               w_pop;
  logic [c_cw:0]      w_occ;

  assign w_accept = in_valid & in_ready;

  // Stage 1: capture the accepted operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_SUB;
      r_s1_rs    <= '0;
      r_s1_rt    <= '0;
      r_s1_tag   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_op  <= op_e'(in_op);
        r_s1_rs  <= in_rs;
        r_s1_rt  <= in_rt;
        r_s1_tag <= in_tag;
      end
    end
  end

  assign w_sum  = {1'b0, r_s1_rs} + {1'b0, r_s1_rt};
  assign w_diff = {1'b0, r_s1_rs} - {1'b0, r_s1_rt};

  always_comb begin
    w_rd    = '0;
    w_carry = 1'b0;
    case (r_s1_op)
      OP_SUB: begin
        w_rd    = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
      end
      OP_ADD: begin
        w_rd    = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
      end
      OP_OR:  w_rd = r_s1_rs | r_s1_rt;
      OP_AND: w_rd = r_s1_rs & r_s1_rt;
      OP_SRA: w_rd = {r_s1_rt[WIDTH-1], r_s1_rt[WIDTH-1:1]};
      OP_ROL: w_rd = {r_s1_rs[WIDTH-2:0], r_s1_rs[WIDTH-1]};
      OP_SLT: begin
        w_rd[WIDTH-1] = 1'b1;
        w_rd[1]       = 1'b1;
        w_rd[0]       = (r_s1_rs < r_s1_rt);
      end
      OP_SEQ: begin
        w_rd    = '1;
        w_rd[0] = (r_s1_rs == r_s1_rt);
      end
      default: begin
        w_rd    = '0;
        w_carry = 1'b0;
      end
    endcase
    if (!op_has_carry(r_s1_op)) begin
      w_carry = 1'b0;
    end
  end

  assign w_zero = (w_rd == '0);

  // Stage 2: hold the finished result for the FIFO push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= {w_rd, w_carry, w_zero, r_s1_tag};
      end
    end
  end

  assign w_pop = out_valid & out_ready;

  de_result_fifo #(
    .WIDTH (c_fw),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (r_s2_valid),
    .pop   (w_pop),
    .din   (r_s2_data),
    .dout  (w_fifo_dout),
    .count (w_fifo_count),
    .empty (w_fifo_empty)
  );

  // Ops still in the pipe already own a FIFO slot, so count them as credit used.
  assign w_occ    = {1'b0, w_fifo_count}
                  + {{c_cw{1'b0}}, r_s1_valid}
                  + {{c_cw{1'b0}}, r_s2_valid};
  assign in_ready = (w_occ < c_depth);

  assign out_valid = ~w_fifo_empty;
  assign out_rd    = w_fifo_dout[c_fw-1 -: WIDTH];
  assign out_carry = w_fifo_dout[TAG_W+1];
  assign out_zero  = w_fifo_dout[TAG_W];
  assign out_tag   = w_fifo_dout[TAG_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_decode_execute_pipe.sv
// ============================================================================
// Module : tb_decode_execute_pipe
// Brief  : Scoreboard bench for decode_execute_pipe with a reference ALU model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_decode_execute_pipe;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int TW = 4;

  typedef logic [W+2+TW-1:0] exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = '0;
  logic [W-1:0]  in_rs = '0;
  logic [W-1:0]  in_rt = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_rd;
  logic          out_carry;
  logic          out_zero;
  logic [TW-1:0] out_tag;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  bit   stall_en = 1'b0;

  always #5 clk = ~clk;

  decode_execute_pipe #(.WIDTH(W), .DEPTH(D), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rd    (out_rd),
    .out_carry (out_carry),
    .out_zero  (out_zero),
    .out_tag   (out_tag)
  );

  // Reference ALU written from the opcode table with plain integer arithmetic.
  function automatic exp_t model(int op, int rs, int rt, int tag);
    int m, rd, cy;
    m  = 2 ** W;
    cy = 0;
    case (op)
      0: begin rd = (rs - rt + m) % m; cy = (rs < rt) ? 1 : 0; end
      1: begin rd = (rs + rt) % m;     cy = (rs + rt >= m) ? 1 : 0; end
      2: rd = rs | rt;
      3: rd = rs & rt;
      4: rd = rt / 2 + ((rt >= m / 2) ? m / 2 : 0);
      5: rd = (rs * 2) % m + rs / (m / 2);
      6: rd = m / 2 + 2 + ((rs < rt) ? 1 : 0);
      default: rd = m - 2 + ((rs == rt) ? 1 : 0);
    endcase
    return {W'(rd), 1'(cy), (rd == 0), TW'(tag)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got rd=%0h tag=%0h, expected no output", out_rd, out_tag);
      end else begin
        mon_e = sb.pop_front();
        check("result", 32'({out_rd, out_carry, out_zero, out_tag}), 32'(mon_e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (stall_en) out_ready = ($urandom_range(3) != 0);
  endtask

  task automatic send(input int op, input int rs, input int rt, input int tag);
    int  guard;
    bit  done;
    guard = 0;
    done  = 1'b0;
    in_valid = 1'b1;
    in_op    = 3'(op);
    in_rs    = W'(rs);
    in_rt    = W'(rt);
    in_tag   = TW'(tag);
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(op, rs, rt, tag));
        done = 1'b1;
      end
      tick();
      guard++;
      if (!done && guard > 200) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: got no in_ready in %0d cycles, expected acceptance", guard);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 500) begin
      tick();
      g++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    repeat (3) tick();
  endtask

  initial begin
    int k;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_rd",    32'(out_rd),    32'd0);
    check("rst_out_carry", 32'(out_carry), 32'd0);
    check("rst_out_zero",  32'(out_zero),  32'd0);
    check("rst_out_tag",   32'(out_tag),   32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // latency: head valid only after the second edge past acceptance
    send(0, 0, 1, 1);
    @(negedge clk); check("lat_edge0", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk); check("lat_edge1", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk); check("lat_edge2", 32'(out_valid), 32'd1);
    tick();
    drain();

    send(1, 15, 1, 2);
    send(2, 5, 10, 3);
    send(3, 6, 3, 4);
    send(4, 0, 8, 5);
    send(5, 9, 0, 6);
    send(6, 3, 5, 7);
    send(6, 5, 3, 8);
    send(7, 7, 7, 9);
    send(7, 7, 6, 10);
    drain();

    // backpressure: fill to capacity with the consumer stalled
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_op    = 3'd2;
      in_rs    = W'(k);
      in_rt    = '0;
      in_tag   = TW'(k);
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(2, k, 0, k));
        k++;
      end
      tick();
    end
    in_valid = 1'b0;
    check("accepted_at_full", 32'(k), 32'd4);
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_out_valid", 32'(out_valid), 32'd1);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("ready_same_cycle", 32'(in_ready), 32'd0);
    tick();
    @(negedge clk);
    check("ready_next_cycle", 32'(in_ready), 32'd1);
    tick();
    send(2, 4, 0, 4);
    send(2, 5, 0, 5);
    drain();

    // asynchronous reset with ops in flight
    out_ready = 1'b0;
    send(1, 1, 1, 9);
    send(1, 2, 2, 10);
    send(1, 3, 3, 11);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check("mid_rst_out_tag",   32'(out_tag),   32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    send(1, 3, 4, 7);
    drain();

    // exhaustive operand sweep with random consumer stalls
    stall_en = 1'b1;
    for (int op = 0; op < 8; op++) begin
      for (int p = 0; p < 256; p++) begin
        send(op, p / 16, p % 16, int'($urandom_range(15)));
      end
    end
    stall_en  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
